seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 158 +++++++++++++++
 tb/tb_seq_divider.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential 16/8 unsigned restoring divider: one quotient bit per clock, IDLE/RUN/DONE control.
// Optional macro SEQ_DIV_ZERO_CHECK_EN enables early divide-by-zero detection and the div_by_zero flag.
module seq_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] dataa,
  input  logic [7:0]  datab,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      next_s;

  logic [15:0] dividend_r;
  logic [7:0]  divisor_r;
  logic [8:0]  partial_r;
  logic [15:0] quot_sh_r;
  logic [3:0]  count_r;
  logic [15:0] quotient_r;
  logic [7:0]  remainder_r;
  logic        busy_r;
  logic        done_r;
  logic        dbz_r;

  logic [8:0]  shifted_s;
  logic        ge_s;
  logic [8:0]  diff_s;
  logic [15:0] qnext_s;
  logic        zero_hit_s;

`ifdef SEQ_DIV_ZERO_CHECK_EN
  assign zero_hit_s = (divisor_r == 8'd0);
`else
  // Without early detection a zero divisor simply runs all 16 steps (yielding all-ones quotient).
  assign zero_hit_s = 1'b0;
`endif

  // One restoring step: bring in the next dividend bit and conditionally subtract.
  always_comb begin
    shifted_s = {partial_r[7:0], dividend_r[15]};
    ge_s      = 1'b0;
    diff_s    = shifted_s;
    if (shifted_s >= {1'b0, divisor_r}) begin
      ge_s   = 1'b1;
      diff_s = shifted_s - {1'b0, divisor_r};
    end else begin
      ge_s   = 1'b0;
      diff_s = shifted_s;
    end
    qnext_s = {quot_sh_r[14:0], ge_s};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_s = RUN;
        end else begin
          next_s = IDLE;
        end
      end
      RUN: begin
        if (zero_hit_s || (count_r == 4'd15)) begin
          next_s = DONE;
        end else begin
          next_s = RUN;
        end
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Datapath, result and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dividend_r  <= 16'd0;
      divisor_r   <= 8'd0;
      partial_r   <= 9'd0;
      quot_sh_r   <= 16'd0;
      count_r     <= 4'd0;
      quotient_r  <= 16'd0;
      remainder_r <= 8'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            dividend_r <= dataa;
            divisor_r  <= datab;
            partial_r  <= 9'd0;
            quot_sh_r  <= 16'd0;
            count_r    <= 4'd0;
            dbz_r      <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        RUN: begin
          if (zero_hit_s) begin
            quotient_r  <= 16'hFFFF;
            remainder_r <= dividend_r[7:0];
            dbz_r       <= 1'b1;
            done_r      <= 1'b1;
          end else begin
            dividend_r <= {dividend_r[14:0], 1'b0};
            partial_r  <= diff_s;
            quot_sh_r  <= qnext_s;
            count_r    <= count_r + 4'd1;
            // Results are published only on the final step so they stay stable otherwise.
            if (count_r == 4'd15) begin
              quotient_r  <= qnext_s;
              remainder_r <= diff_s[7:0];
              done_r      <= 1'b1;
            end
          end
        end
        DONE: begin
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus randomized operations
// compared against an arithmetic reference model.
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] dataa;
  logic [7:0]  datab;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_tests;
  int n_fail;

`ifdef SEQ_DIV_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  seq_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dataa       (dataa),
    .datab       (datab),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic; edges from accept to done is 16 (done in the 17th cycle).
  task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] q, output logic [7:0] r,
                         output logic dz, output int lat);
    if (b == 8'd0) begin
      q   = 16'hFFFF;
      r   = a[7:0];
      dz  = ZC;
      lat = ZC ? 1 : 16;
    end else begin
      q   = a / {8'd0, b};
      r   = 8'(a % {8'd0, b});
      dz  = 1'b0;
      lat = 16;
    end
  endtask

  // One operation; inject_at >= 0 pulses a competing start (50/5) that many edges into RUN.
  task automatic run_op(input string name, input logic [15:0] a, input logic [7:0] b, input int inject_at);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ed;
    int          el;
    int          lat;
    bit          busy_ok;
    ref_div(a, b, eq, er, ed, el);
    dataa = a;
    datab = b;
    start = 1'b1;
    tick();
    start   = 1'b0;
    dataa   = 16'($urandom);
    datab   = 8'($urandom);
    lat     = 0;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (lat == inject_at) begin
        start = 1'b1;
        dataa = 16'd50;
        datab = 8'd5;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check_eq({name, " latency"}, lat, el);
    check_eq({name, " busy_run"}, {31'd0, busy_ok & busy}, 32'd1);
    check_eq({name, " quotient"}, quotient, eq);
    check_eq({name, " remainder"}, remainder, er);
    check_eq({name, " div_by_zero"}, div_by_zero, ed);
    tick();
    check_eq({name, " done_pulse"}, done, 1'b0);
    check_eq({name, " busy_idle"}, busy, 1'b0);
    dataa = 16'($urandom);
    datab = 8'($urandom);
    tick();
    check_eq({name, " hold_q"}, quotient, eq);
    check_eq({name, " hold_r"}, remainder, er);
  endtask

  initial begin
    int          e;
    int          last;
    int          found;
    logic [15:0] ra;
    logic [7:0]  rb;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    dataa   = 16'd0;
    datab   = 8'd0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst quotient", quotient, 16'd0);
    check_eq("rst remainder", remainder, 8'd0);
    check_eq("rst busy", busy, 1'b0);
    check_eq("rst done", done, 1'b0);
    check_eq("rst dbz", div_by_zero, 1'b0);

    run_op("1000/7", 16'd1000, 8'd7, -1);
    run_op("ffff/ff", 16'hFFFF, 8'hFF, -1);
    run_op("5/10", 16'h0005, 8'h0A, -1);
    run_op("1234/0", 16'h1234, 8'd0, -1);
    run_op("100/3 inj", 16'd100, 8'd3, 5);

    // Reset in the middle of a run discards the operation.
    dataa = 16'd500;
    datab = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst busy", busy, 1'b0);
    check_eq("midrst done", done, 1'b0);
    check_eq("midrst quotient", quotient, 16'd0);
    check_eq("midrst remainder", remainder, 8'd0);
    run_op("500/9", 16'd500, 8'd9, -1);

    // Reset wins over start on the same edge.
    reset = 1'b1;
    start = 1'b1;
    dataa = 16'd77;
    datab = 8'd3;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check_eq("rst_prio busy", busy, 1'b0);
    tick();
    check_eq("rst_prio idle", busy, 1'b0);

    // Start held high: one accept every 18 cycles.
    dataa = 16'd200;
    datab = 8'd10;
    start = 1'b1;
    tick();
    e     = 0;
    last  = -1;
    found = 0;
    while (found < 3 && e < 100) begin
      if (done) begin
        check_eq("b2b quotient", quotient, 16'd20);
        check_eq("b2b remainder", remainder, 8'd0);
        if (last >= 0) check_eq("b2b interval", e - last, 18);
        last = e;
        found++;
      end
      tick();
      e++;
    end
    start = 1'b0;
    check_eq("b2b count", found, 3);
    check_eq("b2b first", last - 36, 16);

    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      run_op("rand", ra, rb, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
